pipe_hazard_ctrl: RTL

- Pipeline sequencer for the 5-stage core.
- Drives the write enables and squash controls of the PC, the fetch/decode register and the decode/execute register.
- Resolves load-use hazards, taken-branch redirects, multi-cycle MDU (multiply/divide) occupancy and external memory holds.
- Keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: PC / F-D / D-E enables and squashes,
// load-use and MDU occupancy stalls, branch redirects, memory holds, stall counter.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int SCW     = 16
) (
    input  logic           clk,
    input  logic           rstd,
    input  logic [5:0]     op_d,
    input  logic [4:0]     rs_d,
    input  logic [4:0]     rt_d,
    input  logic           uses_rs_d,
    input  logic           uses_rt_d,
    input  logic           mdu_d,
    input  logic           ld_e,
    input  logic [4:0]     wreg_e,
    input  logic           br_taken_e,
    input  logic           ext_hold,
    input  logic           stall_clr,
    output logic           pc_we,
    output logic           fd_we,
    output logic           fd_flush,
    output logic           de_we,
    output logic           de_bubble,
    output logic           mdu_start,
    output logic           mdu_busy,
    output logic [SCW-1:0] stall_cnt
);

    localparam logic [5:0] OP_NOP = 6'b110111;

    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t         state, state_nxt;
    logic [5:0]     wcnt, wcnt_nxt;
    logic [SCW-1:0] stall_cnt_nxt;
    logic           stall_inc;
    logic           load_use;

    function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = ld_e && (wreg_e != 5'd0) &&
                      ((uses_rs_d && (rs_d == wreg_e)) || (uses_rt_d && (rt_d == wreg_e)));

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            state     <= RUN;
            wcnt      <= 6'd0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        stall_inc = 1'b0;
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        fd_flush  = 1'b0;
        de_we     = 1'b1;
        de_bubble = 1'b0;
        mdu_start = 1'b0;
        mdu_busy  = (state == MDU_WAIT);

        if (rstd) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            mdu_busy  = 1'b0;
        end else if (ext_hold) begin
            pc_we = 1'b0;
            fd_we = 1'b0;
            de_we = 1'b0;
        end else if (br_taken_e) begin
            // Redirect squashes both front-end registers and abandons any MDU wait.
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            state_nxt = RUN;
            wcnt_nxt  = 6'd0;
        end else if (state == MDU_WAIT) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            de_bubble = 1'b1;
            stall_inc = 1'b1;
            if (wcnt == 6'd0) begin
                state_nxt = RUN;
            end else begin
                wcnt_nxt = wcnt - 6'd1;
            end
        end else if (load_use) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            de_bubble = 1'b1;
            stall_inc = 1'b1;
        end else if (mdu_d) begin
            mdu_start = 1'b1;
            state_nxt = MDU_WAIT;
            wcnt_nxt  = 6'(MDU_LAT - 1);
        end
    end

    // A hold freezes the counter entirely, clear included.
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (!ext_hold) begin
            if (stall_clr) begin
                stall_cnt_nxt = '0;
            end else if (stall_inc) begin
                stall_cnt_nxt = sat_inc(stall_cnt);
            end
        end
    end

    a_no_nop_mdu_issue: assert property (@(posedge clk) disable iff (rstd)
        !(mdu_start && (op_d == OP_NOP)));

endmodule
